// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch/next-PC sequencer of the single-cycle RV32I datapath.
package pc_sequencer_pkg;

    localparam int unsigned INSTRUCTION_SIZE = 32;
    localparam int unsigned PC_STEP          = 4;

    localparam logic [INSTRUCTION_SIZE-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [INSTRUCTION_SIZE-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        SEQ_BOOT   = 2'b00,
        SEQ_FETCH  = 2'b01,
        SEQ_ISSUE  = 2'b10,
        SEQ_HALTED = 2'b11
    } seq_state_e;

    function automatic logic word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and memory (slave).
interface pc_sequencer_if #(
    parameter int unsigned XLEN = pc_sequencer_pkg::INSTRUCTION_SIZE
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic [31:0]     rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/pc_sequencer_pc.sv
// Program counter register with a qualified load; reset is active-high here.
module pc_sequencer_pc #(
    parameter int unsigned    XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VALUE = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_out
);
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (en) begin
            pc_d = pc_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VALUE;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_out = pc_q;
endmodule

// File: rtl/pc_sequencer.sv
// Fetch/next-PC controller: fetch handshake, issue hold, trap/mret/redirect PC selection,
// EPC capture, halt/resume and retire strobe.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     XLEN         = INSTRUCTION_SIZE,
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_sequencer_if.master        imem,
    output logic [31:0]           instr_out,
    output logic                  instr_valid,
    output logic [XLEN-1:0]       pc_out,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [XLEN-1:0]       redirect_target,
    input  logic                  trap,
    input  logic                  mret,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic [XLEN-1:0]       epc_out,
    output logic                  misaligned,
    output logic                  retire,
    output logic                  halted
);
    seq_state_e      state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            misaligned_q, misaligned_d;
    logic            retire_q, retire_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic            pc_en;
    logic            rst_h;

    assign rst_h = ~rst;

    pc_sequencer_pc #(
        .XLEN        (XLEN),
        .RESET_VALUE (RESET_VECTOR)
    ) u_pc (
        .clk    (clk),
        .rst    (rst_h),
        .en     (pc_en),
        .pc_in  (pc_next),
        .pc_out (pc_q)
    );

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        epc_d        = epc_q;
        misaligned_d = misaligned_q;
        retire_d     = 1'b0;
        pc_en        = 1'b0;
        pc_next      = pc_q + XLEN'(PC_STEP);

        case (state_q)
            SEQ_BOOT: begin
                state_d = SEQ_FETCH;
            end
            SEQ_FETCH: begin
                if (imem.ready) begin
                    instr_d = imem.rdata;
                    state_d = SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                if (!stall) begin
                    pc_en    = 1'b1;
                    retire_d = 1'b1;
                    state_d  = halt_req ? SEQ_HALTED : SEQ_FETCH;
                    // A misaligned redirect enters the trap vector exactly like trap.
                    if (trap) begin
                        epc_d   = pc_q;
                        pc_next = TRAP_VECTOR;
                    end else if (mret) begin
                        pc_next      = epc_q;
                        misaligned_d = 1'b0;
                    end else if (redirect && word_aligned(redirect_target[1:0])) begin
                        pc_next = redirect_target;
                    end else if (redirect) begin
                        epc_d        = pc_q;
                        pc_next      = TRAP_VECTOR;
                        misaligned_d = 1'b1;
                    end
                end
            end
            SEQ_HALTED: begin
                if (resume) begin
                    state_d = SEQ_FETCH;
                end
            end
            default: begin
                state_d = SEQ_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SEQ_BOOT;
            instr_q      <= '0;
            epc_q        <= '0;
            misaligned_q <= 1'b0;
            retire_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            epc_q        <= epc_d;
            misaligned_q <= misaligned_d;
            retire_q     <= retire_d;
        end
    end

    // retire is registered so no input reaches an output combinationally; it is high
    // in the cycle right after the instruction leaves ISSUE, alongside the updated pc.
    assign retire      = retire_q;
    assign imem.req    = (state_q == SEQ_FETCH);
    assign imem.addr   = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = (state_q == SEQ_ISSUE);
    assign halted      = (state_q == SEQ_HALTED);
    assign pc_out      = pc_q;
    assign epc_out     = epc_q;
    assign misaligned  = misaligned_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer plus stall and mid-fetch reset sequences.
module tb_pc_sequencer;

    localparam logic [6:0] I_RDY = 7'b0000001;
    localparam logic [6:0] I_RES = 7'b0000010;
    localparam logic [6:0] I_HLT = 7'b0000100;
    localparam logic [6:0] I_MRT = 7'b0001000;
    localparam logic [6:0] I_TRP = 7'b0010000;
    localparam logic [6:0] I_RED = 7'b0100000;
    localparam logic [6:0] I_STL = 7'b1000000;

    localparam logic [4:0] O_REQ = 5'b10000;
    localparam logic [4:0] O_VAL = 5'b01000;
    localparam logic [4:0] O_HLT = 5'b00100;
    localparam logic [4:0] O_RET = 5'b00010;
    localparam logic [4:0] O_MIS = 5'b00001;

    typedef struct {
        logic [6:0]  fin;
        logic [31:0] tgt;
        logic [31:0] rdata;
        logic [4:0]  fout;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] instr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic        stall, redirect, trap, mret, halt_req, resume;
    logic [31:0] redirect_target;
    logic [31:0] epc_out;
    logic        misaligned, retire, halted;

    int unsigned errors = 0;
    int unsigned checks = 0;
    vec_t        vecs[32];

    pc_sequencer_if #(.XLEN(32)) imem_if ();

    pc_sequencer #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem            (imem_if),
        .instr_out       (instr_out),
        .instr_valid     (instr_valid),
        .pc_out          (pc_out),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .trap            (trap),
        .mret            (mret),
        .halt_req        (halt_req),
        .resume          (resume),
        .epc_out         (epc_out),
        .misaligned      (misaligned),
        .retire          (retire),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic [6:0] fin, input logic [31:0] tgt, input logic [31:0] rdata,
                               input logic [4:0] fout, input logic [31:0] pc, input logic [31:0] epc,
                               input logic [31:0] instr);
        vec_t r;
        r.fin = fin; r.tgt = tgt; r.rdata = rdata;
        r.fout = fout; r.pc = pc; r.epc = epc; r.instr = instr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [6:0] fin, input logic [31:0] tgt, input logic [31:0] rdata);
        stall           = fin[6];
        redirect        = fin[5];
        trap            = fin[4];
        mret            = fin[3];
        halt_req        = fin[2];
        resume          = fin[1];
        imem_if.ready   = fin[0];
        redirect_target = tgt;
        imem_if.rdata   = rdata;
    endtask

    task automatic chk_all(input string tag, input logic [4:0] fout, input logic [31:0] pc,
                           input logic [31:0] epc, input logic [31:0] instr);
        chk({tag, " imem_req"}, 32'(imem_if.req), 32'(fout[4]));
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'(fout[3]));
        chk({tag, " halted"}, 32'(halted), 32'(fout[2]));
        chk({tag, " retire"}, 32'(retire), 32'(fout[1]));
        chk({tag, " misaligned"}, 32'(misaligned), 32'(fout[0]));
        chk({tag, " pc_out"}, pc_out, pc);
        chk({tag, " imem_addr"}, imem_if.addr, pc);
        chk({tag, " epc_out"}, epc_out, epc);
        chk({tag, " instr_out"}, instr_out, instr);
    endtask

    initial begin
        vecs[0]  = v(I_RDY, 32'h0, 32'h11, O_REQ, 32'h0, 32'h0, 32'h0);
        vecs[1]  = v(I_RDY, 32'h0, 32'hAA, O_VAL, 32'h0, 32'h0, 32'hAA);
        vecs[2]  = v(I_RDY, 32'h0, 32'h99, O_REQ | O_RET, 32'h4, 32'h0, 32'hAA);
        vecs[3]  = v(I_TRP | I_MRT, 32'h0, 32'h0, O_REQ, 32'h4, 32'h0, 32'hAA);
        vecs[4]  = v(7'b0, 32'h0, 32'h0, O_REQ, 32'h4, 32'h0, 32'hAA);
        vecs[5]  = v(I_RDY, 32'h0, 32'hBB, O_VAL, 32'h4, 32'h0, 32'hBB);
        vecs[6]  = v(7'b0, 32'h0, 32'h0, O_REQ | O_RET, 32'h8, 32'h0, 32'hBB);
        vecs[7]  = v(I_RDY, 32'h0, 32'hCC, O_VAL, 32'h8, 32'h0, 32'hCC);
        vecs[8]  = v(I_RED, 32'h40, 32'h0, O_REQ | O_RET, 32'h40, 32'h0, 32'hCC);
        vecs[9]  = v(I_RDY, 32'h0, 32'hDD, O_VAL, 32'h40, 32'h0, 32'hDD);
        vecs[10] = v(I_RED, 32'h44, 32'h0, O_REQ | O_RET, 32'h44, 32'h0, 32'hDD);
        vecs[11] = v(I_RDY, 32'h0, 32'hEE, O_VAL, 32'h44, 32'h0, 32'hEE);
        vecs[12] = v(I_TRP, 32'h0, 32'h0, O_REQ | O_RET, 32'h100, 32'h44, 32'hEE);
        vecs[13] = v(I_RDY, 32'h0, 32'h01, O_VAL, 32'h100, 32'h44, 32'h01);
        vecs[14] = v(I_MRT, 32'h0, 32'h0, O_REQ | O_RET, 32'h44, 32'h44, 32'h01);
        vecs[15] = v(I_RDY, 32'h0, 32'h02, O_VAL, 32'h44, 32'h44, 32'h02);
        vecs[16] = v(I_RED, 32'h20, 32'h0, O_REQ | O_RET, 32'h20, 32'h44, 32'h02);
        vecs[17] = v(I_RDY, 32'h0, 32'h03, O_VAL, 32'h20, 32'h44, 32'h03);
        vecs[18] = v(I_RED, 32'h42, 32'h0, O_REQ | O_RET | O_MIS, 32'h100, 32'h20, 32'h03);
        vecs[19] = v(I_RDY, 32'h0, 32'h04, O_VAL | O_MIS, 32'h100, 32'h20, 32'h04);
        vecs[20] = v(I_MRT, 32'h0, 32'h0, O_REQ | O_RET, 32'h20, 32'h20, 32'h04);
        vecs[21] = v(I_RDY, 32'h0, 32'h05, O_VAL, 32'h20, 32'h20, 32'h05);
        vecs[22] = v(I_TRP | I_MRT | I_RED, 32'h80, 32'h0, O_REQ | O_RET, 32'h100, 32'h20, 32'h05);
        vecs[23] = v(I_RDY, 32'h0, 32'h06, O_VAL, 32'h100, 32'h20, 32'h06);
        vecs[24] = v(I_RED, 32'hFFFF_FFFC, 32'h0, O_REQ | O_RET, 32'hFFFF_FFFC, 32'h20, 32'h06);
        vecs[25] = v(I_RDY, 32'h0, 32'h07, O_VAL, 32'hFFFF_FFFC, 32'h20, 32'h07);
        vecs[26] = v(7'b0, 32'h0, 32'h0, O_REQ | O_RET, 32'h0, 32'h20, 32'h07);
        vecs[27] = v(I_RDY, 32'h0, 32'h08, O_VAL, 32'h0, 32'h20, 32'h08);
        vecs[28] = v(I_HLT, 32'h0, 32'h0, O_HLT | O_RET, 32'h4, 32'h20, 32'h08);
        vecs[29] = v(I_HLT | I_TRP | I_RED | I_RDY, 32'h80, 32'h77, O_HLT, 32'h4, 32'h20, 32'h08);
        vecs[30] = v(I_RES, 32'h0, 32'h0, O_REQ, 32'h4, 32'h20, 32'h08);
        vecs[31] = v(I_RDY, 32'h0, 32'h55, O_VAL, 32'h4, 32'h20, 32'h55);

        rst = 1'b0;
        apply(7'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 5'b0, 32'h0, 32'h0, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("boot imem_req", 32'(imem_if.req), 32'h0);

        for (int i = 0; i < 32; i++) begin
            apply(vecs[i].fin, vecs[i].tgt, vecs[i].rdata);
            @(posedge clk);
            #1;
            chk_all($sformatf("row%0d", i), vecs[i].fout, vecs[i].pc, vecs[i].epc, vecs[i].instr);
        end

        // Stalled ISSUE with events pulsing: nothing may move.
        for (int i = 0; i < 5; i++) begin
            apply(I_STL | I_RDY | ((i % 2 == 0) ? I_RED : 7'b0) | ((i == 2) ? I_TRP : 7'b0)
                  | ((i == 3) ? I_HLT : 7'b0), 32'h80, 32'h99);
            @(posedge clk);
            #1;
            chk_all($sformatf("stall%0d", i), O_VAL, 32'h4, 32'h20, 32'h55);
        end
        apply(7'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk_all("unstall", O_REQ | O_RET, 32'h8, 32'h20, 32'h55);

        // Reset in the middle of a fetch: outputs clear before any clock edge.
        #3;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 5'b0, 32'h0, 32'h0, 32'h0);
        apply(I_RDY, 32'h0, 32'h12);
        @(posedge clk);
        #1;
        chk_all("rst_held", 5'b0, 32'h0, 32'h0, 32'h0);
        #3;
        rst = 1'b1;
        apply(I_RDY, 32'h0, 32'h12);
        @(posedge clk);
        #1;
        chk_all("reboot", O_REQ, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk_all("refetch", O_VAL, 32'h0, 32'h0, 32'h12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
